instr_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined CPU. It sits directly upstream of the IF/ID pipeline register. It owns the PC, issues one request at a time to instruction memory over a req/ack handshake, and presents each fetched word with its address. It also raises a stall towards IF/ID while no valid word is available, and honours load-use hazard holds and branch redirects from ID.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single outstanding requests to
// instruction memory, holds the fetched word for IF/ID, and tracks redirects
// that arrive while a request is still outstanding.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        hazardDetected_i,
  input  logic        branchTaken_i,
  input  logic [31:0] branchTarget_i,
  output logic        memReq_o,
  output logic [31:0] memAddr_o,
  input  logic        memAck_i,
  input  logic [31:0] memData_i,
  output logic [31:0] instr_o,
  output logic [31:0] instrAddr_o,
  output logic        fetchStall_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_addr_q, instr_addr_d;
  logic              redir_pending_q, redir_pending_d;
  logic [XLEN-1:0]   redir_target_q, redir_target_d;
  logic [XLEN-1:0]   branch_tgt;

  // Redirect targets are always word aligned
  assign branch_tgt = branchTarget_i & ~XLEN'(32'h3);

  // Request and stall are pure decodes of the current state so reset drops them at once
  assign memReq_o     = (state_q == FETCH);
  assign memAddr_o    = pc_q;
  assign fetchStall_o = (state_q != READY);
  assign instr_o      = instr_q;
  assign instrAddr_o  = instr_addr_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      instr_q         <= '0;
      instr_addr_q    <= '0;
      redir_pending_q <= 1'b0;
      redir_target_q  <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      instr_addr_q    <= instr_addr_d;
      redir_pending_q <= redir_pending_d;
      redir_target_q  <= redir_target_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    instr_addr_d    = instr_addr_q;
    redir_pending_d = redir_pending_q;
    redir_target_d  = redir_target_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (memAck_i) begin
          if (branchTaken_i) begin
            // Returned word belongs to the wrong path; refetch from the new target
            pc_d            = branch_tgt;
            redir_pending_d = 1'b0;
          end else if (redir_pending_q) begin
            pc_d            = redir_target_q;
            redir_pending_d = 1'b0;
          end else begin
            instr_d      = memData_i;
            instr_addr_d = pc_q;
            state_d      = READY;
          end
        end else if (branchTaken_i) begin
          // Address must stay stable until ack, so remember the redirect for later
          redir_pending_d = 1'b1;
          redir_target_d  = branch_tgt;
        end
      end

      READY: begin
        if (branchTaken_i) begin
          pc_d    = branch_tgt;
          state_d = FETCH;
        end else if (!hazardDetected_i) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple configurable memory.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        hazardDetected_i;
  logic        branchTaken_i;
  logic [31:0] branchTarget_i;
  logic        memReq_o;
  logic [31:0] memAddr_o;
  logic        memAck_i;
  logic [31:0] memData_i;
  logic [31:0] instr_o;
  logic [31:0] instrAddr_o;
  logic        fetchStall_o;

  logic ack_en;
  logic ack_force;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .hazardDetected_i (hazardDetected_i),
    .branchTaken_i    (branchTaken_i),
    .branchTarget_i   (branchTarget_i),
    .memReq_o         (memReq_o),
    .memAddr_o        (memAddr_o),
    .memAck_i         (memAck_i),
    .memData_i        (memData_i),
    .instr_o          (instr_o),
    .instrAddr_o      (instrAddr_o),
    .fetchStall_o     (fetchStall_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: returns addr ^ A5A5_0000, acks in the request cycle when enabled
  always_comb begin
    memData_i = memAddr_o ^ 32'hA5A5_0000;
    memAck_i  = ack_force | (ack_en & memReq_o);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i            = 1'b0;
    start_i          = 1'b0;
    hazardDetected_i = 1'b0;
    branchTaken_i    = 1'b0;
    branchTarget_i   = 32'h0;
    ack_en           = 1'b1;
    ack_force        = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req",   32'(memReq_o), 32'd0);
    chk("rst_stall", 32'(fetchStall_o), 32'd1);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_iaddr", instrAddr_o, 32'h0);
    chk("rst_maddr", memAddr_o, 32'h0);

    rst_i = 1'b1;
    tick();
    // Branch in IDLE is ignored
    branchTaken_i  = 1'b1;
    branchTarget_i = 32'h0000_0080;
    tick();
    branchTaken_i = 1'b0;
    chk("idle_req",   32'(memReq_o), 32'd0);
    chk("idle_maddr", memAddr_o, 32'h0);

    // Zero-wait fetch sequence
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("f0_req",   32'(memReq_o), 32'd1);
    chk("f0_maddr", memAddr_o, 32'h0);
    chk("f0_stall", 32'(fetchStall_o), 32'd1);
    tick();
    chk("r0_instr", instr_o, 32'hA5A5_0000);
    chk("r0_iaddr", instrAddr_o, 32'h0);
    chk("r0_stall", 32'(fetchStall_o), 32'd0);
    chk("r0_req",   32'(memReq_o), 32'd0);
    tick();
    chk("f1_maddr", memAddr_o, 32'h4);
    chk("f1_stall", 32'(fetchStall_o), 32'd1);
    tick();
    chk("r1_instr", instr_o, 32'hA5A5_0004);
    chk("r1_stall", 32'(fetchStall_o), 32'd0);

    // Three wait cycles at pc=8
    ack_en = 1'b0;
    tick();
    chk("w_maddr0", memAddr_o, 32'h8);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("w_maddr", memAddr_o, 32'h8);
      chk("w_req",   32'(memReq_o), 32'd1);
      chk("w_stall", 32'(fetchStall_o), 32'd1);
    end
    ack_en = 1'b1;
    tick();
    chk("w_iaddr", instrAddr_o, 32'h8);
    chk("w_instr", instr_o, 32'hA5A5_0008);
    chk("w_stall_r", 32'(fetchStall_o), 32'd0);

    // Hazard hold in READY at pc=12
    tick();
    chk("h_maddr_f", memAddr_o, 32'hC);
    tick();
    chk("h_iaddr0", instrAddr_o, 32'hC);
    hazardDetected_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_instr", instr_o, 32'hA5A5_000C);
      chk("h_iaddr", instrAddr_o, 32'hC);
      chk("h_req",   32'(memReq_o), 32'd0);
      chk("h_stall", 32'(fetchStall_o), 32'd0);
    end
    hazardDetected_i = 1'b0;
    tick();
    chk("h_next", memAddr_o, 32'h10);
    tick();
    chk("h_iaddr16", instrAddr_o, 32'h10);

    // Branch during unacked FETCH at pc=20
    ack_en = 1'b0;
    tick();
    chk("b_maddr20", memAddr_o, 32'h14);
    branchTaken_i  = 1'b1;
    branchTarget_i = 32'h0000_0103;
    tick();
    branchTaken_i  = 1'b0;
    branchTarget_i = 32'h0;
    chk("b_hold1", memAddr_o, 32'h14);
    tick();
    chk("b_hold2", memAddr_o, 32'h14);
    ack_en = 1'b1;
    tick();
    chk("b_redir",   memAddr_o, 32'h100);
    chk("b_req",     32'(memReq_o), 32'd1);
    chk("b_noready", 32'(fetchStall_o), 32'd1);
    chk("b_iaddr",   instrAddr_o, 32'h10);
    tick();
    chk("b_iaddr_r", instrAddr_o, 32'h100);
    chk("b_instr_r", instr_o, 32'hA5A5_0100);

    // Branch overrides hazard in READY
    branchTaken_i    = 1'b1;
    hazardDetected_i = 1'b1;
    branchTarget_i   = 32'h0000_0040;
    tick();
    branchTaken_i    = 1'b0;
    hazardDetected_i = 1'b0;
    chk("bh_maddr", memAddr_o, 32'h40);
    tick();
    chk("bh_iaddr", instrAddr_o, 32'h40);

    // PC wrap
    branchTaken_i  = 1'b1;
    branchTarget_i = 32'hFFFF_FFFC;
    tick();
    branchTaken_i = 1'b0;
    chk("wr_maddr", memAddr_o, 32'hFFFF_FFFC);
    tick();
    chk("wr_iaddr", instrAddr_o, 32'hFFFF_FFFC);
    chk("wr_instr", instr_o, 32'h5A5A_FFFC);
    tick();
    chk("wr_next", memAddr_o, 32'h0);
    chk("wr_req",  32'(memReq_o), 32'd1);

    // Asynchronous reset mid-request
    rst_i = 1'b0;
    #1;
    chk("ar_req",   32'(memReq_o), 32'd0);
    chk("ar_stall", 32'(fetchStall_o), 32'd1);
    chk("ar_instr", instr_o, 32'h0);
    chk("ar_iaddr", instrAddr_o, 32'h0);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    chk("ar_ack_req",   32'(memReq_o), 32'd0);
    chk("ar_ack_instr", instr_o, 32'h0);
    chk("ar_ack_maddr", memAddr_o, 32'h0);
    rst_i = 1'b1;
    tick();
    chk("ar_post_req",   32'(memReq_o), 32'd0);
    chk("ar_post_stall", 32'(fetchStall_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
